// File: rtl/tap_delay.sv
// -----------------------------------------------------------------------------
// tap_delay
//
// Purpose
//   Fixed-length shift line of D stages with a run-time selectable output tap.
//   Each stage carries an N-bit data word plus a one-bit valid tag. The line
//   advances only on clock-enabled edges; a synchronous clear flushes it.
//   A fill counter tracks how many stages have been written since the last
//   reset/clear, so the selected tap can report whether it holds real data.
//
// Valid/ready semantics
//   There is no ready/backpressure path. in_vld is a tag that travels with
//   in through the line: every ce-qualified edge accepts {in, in_vld}
//   unconditionally, and out_vld is simply that tag read back at the
//   selected tap. A word with in_vld=0 still occupies a stage (a bubble).
//
// Ports
//   clk      in   1    rising-edge clock
//   rst_n    in   1    asynchronous active-low reset (clears line and counter)
//   ce       in   1    clock enable; line shifts only when ce=1
//   clr      in   1    synchronous flush, priority over ce
//   sel      in   SW   tap select (clamped to D-1 when out of range)
//   in       in   N    data in
//   in_vld   in   1    valid tag for in
//   out      out  N    data at the effective tap
//   out_vld  out  1    valid tag at the effective tap
//   primed   out  1    effective tap written since last reset/clr
//   sel_err  out  1    sel > D-1
//
// Timing
//   A sample accepted on ce edge n is visible at out right after ce edge n+t,
//   where t is the effective tap. out/out_vld/primed/sel_err are purely
//   combinational from the registers and sel, so a change of sel is seen
//   in the same cycle.
// -----------------------------------------------------------------------------
module tap_delay #(
    parameter int N  = 1,
    parameter int D  = 4,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          clr,
    input  logic [SW-1:0] sel,
    input  logic [N-1:0]  in,
    input  logic          in_vld,
    output logic [N-1:0]  out,
    output logic          out_vld,
    output logic          primed,
    output logic          sel_err
);

    // Fill counter width: must hold the value D itself.
    localparam int CW = $clog2(D + 1);

    // Highest legal tap index, one bit wider than sel so the comparison
    // below never truncates regardless of how SW relates to D.
    localparam logic [SW:0]   LAST_TAP = (SW + 1)'(D - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(D);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [N-1:0]  s [D];
    logic          v [D];
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < D; k++) begin
                s[k] <= '0;
                v[k] <= 1'b0;
            end
            cnt <= '0;
        end else if (clr) begin
            // Flush wins over ce and acts even with ce=0.
            for (int k = 0; k < D; k++) begin
                s[k] <= '0;
                v[k] <= 1'b0;
            end
            cnt <= '0;
        end else if (ce) begin
            s[0] <= in;
            v[0] <= in_vld;
            for (int k = 1; k < D; k++) begin
                s[k] <= s[k-1];
                v[k] <= v[k-1];
            end
            // Saturate so primed never drops back under continuous ce.
            if (cnt != CNT_FULL) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tap selection
    // -------------------------------------------------------------------------
    logic [SW:0]   sel_wide;
    logic [SW-1:0] tap;

    assign sel_wide = {1'b0, sel};
    // Independent of rst_n: depends only on sel.
    assign sel_err  = (sel_wide > LAST_TAP);
    assign tap      = sel_err ? LAST_TAP[SW-1:0] : sel;

    // Explicit compare-and-select mux rather than a variable array index so
    // the tap width never has to match the array address width.
    always_comb begin
        out     = '0;
        out_vld = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (tap == SW'(k)) begin
                out     = s[k];
                out_vld = v[k];
            end
        end
    end

    // Tap t has been written once at least t+1 ce edges have occurred,
    // i.e. cnt > t. Compared at 32 bits to avoid width coupling of CW/SW.
    logic [31:0] cnt_ext;
    logic [31:0] tap_ext;

    assign cnt_ext = 32'(cnt);
    assign tap_ext = 32'(tap);
    assign primed  = (cnt_ext > tap_ext);

endmodule

// File: tb/tb_tap_delay.sv
module tb_tap_delay;

    localparam int N  = 8;
    localparam int D  = 4;
    localparam int SW = 3;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          clr = 1'b0;
    logic [SW-1:0] sel = '0;
    logic [N-1:0]  in = '0;
    logic          in_vld = 1'b0;
    logic [N-1:0]  out;
    logic          out_vld;
    logic          primed;
    logic          sel_err;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    tap_delay #(.N(N), .D(D), .SW(SW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .clr     (clr),
        .sel     (sel),
        .in      (in),
        .in_vld  (in_vld),
        .out     (out),
        .out_vld (out_vld),
        .primed  (primed),
        .sel_err (sel_err)
    );

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    // Advance one edge; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] d, input logic vld);
        in     = d;
        in_vld = vld;
        ce     = 1'b1;
        step();
    endtask

    task automatic apply_reset();
        ce     = 1'b0;
        clr    = 1'b0;
        in     = '0;
        in_vld = 1'b0;
        rst_n  = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
    endtask

    task automatic fill_a0_a3();
        apply_reset();
        push(8'hA0, 1'b1);
        push(8'hA1, 1'b1);
        push(8'hA2, 1'b1);
        push(8'hA3, 1'b1);
        ce = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        sel = 3'd2;
        apply_reset();
        n_cmp++; if (out !== 8'h00) begin n_err++; $display("FAIL rst_out: got %h exp 00", out); end
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rst_out_vld: got %b exp 0", out_vld); end
        n_cmp++; if (primed !== 1'b0) begin n_err++; $display("FAIL rst_primed: got %b exp 0", primed); end
        n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL rst_sel_err: got %b exp 0", sel_err); end
    endtask

    task automatic test_latency();
        apply_reset();
        sel = 3'd2;
        push(8'h11, 1'b1);
        n_cmp++; if (primed !== 1'b0) begin n_err++; $display("FAIL lat_e1_primed: got %b exp 0", primed); end
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL lat_e1_vld: got %b exp 0", out_vld); end
        push(8'h22, 1'b1);
        n_cmp++; if (primed !== 1'b0) begin n_err++; $display("FAIL lat_e2_primed: got %b exp 0", primed); end
        push(8'h33, 1'b1);
        n_cmp++; if (out !== 8'h11) begin n_err++; $display("FAIL lat_e3_out: got %h exp 11", out); end
        n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL lat_e3_vld: got %b exp 1", out_vld); end
        n_cmp++; if (primed !== 1'b1) begin n_err++; $display("FAIL lat_e3_primed: got %b exp 1", primed); end
        push(8'h44, 1'b1);
        n_cmp++; if (out !== 8'h22) begin n_err++; $display("FAIL lat_e4_out: got %h exp 22", out); end
        ce = 1'b0;
    endtask

    task automatic test_ce_hold();
        apply_reset();
        sel = 3'd2;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        // Two edges with ce=0 and junk on the input.
        ce = 1'b0; in = 8'hEE; in_vld = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (out !== 8'h00) begin n_err++; $display("FAIL hold%0d_out: got %h exp 00", i, out); end
            n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL hold%0d_vld: got %b exp 0", i, out_vld); end
            n_cmp++; if (primed !== 1'b0) begin n_err++; $display("FAIL hold%0d_primed: got %b exp 0", i, primed); end
        end
        // Peek at tap 1 to confirm the held contents were not disturbed.
        sel = 3'd1; #1;
        n_cmp++; if (out !== 8'h11) begin n_err++; $display("FAIL hold_tap1_out: got %h exp 11", out); end
        sel = 3'd2;
        push(8'h33, 1'b1);
        n_cmp++; if (out !== 8'h11) begin n_err++; $display("FAIL hold_e3_out: got %h exp 11", out); end
        n_cmp++; if (primed !== 1'b1) begin n_err++; $display("FAIL hold_e3_primed: got %b exp 1", primed); end
        ce = 1'b0;
    endtask

    task automatic test_sel_clamp();
        fill_a0_a3();
        sel = 3'd5; #1;
        n_cmp++; if (sel_err !== 1'b1) begin n_err++; $display("FAIL sel5_err: got %b exp 1", sel_err); end
        n_cmp++; if (out !== 8'hA0) begin n_err++; $display("FAIL sel5_out: got %h exp A0", out); end
        n_cmp++; if (primed !== 1'b1) begin n_err++; $display("FAIL sel5_primed: got %b exp 1", primed); end
        sel = 3'd7; #1;
        n_cmp++; if (out !== 8'hA0) begin n_err++; $display("FAIL sel7_out: got %h exp A0", out); end
        sel = 3'd4; #1;
        n_cmp++; if (sel_err !== 1'b1) begin n_err++; $display("FAIL sel4_err: got %b exp 1", sel_err); end
        sel = 3'd3; #1;
        n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL sel3_err: got %b exp 0", sel_err); end
        n_cmp++; if (out !== 8'hA0) begin n_err++; $display("FAIL sel3_out: got %h exp A0", out); end
        sel = 3'd1; #1;
        n_cmp++; if (out !== 8'hA2) begin n_err++; $display("FAIL sel1_out: got %h exp A2", out); end
        sel = 3'd0; #1;
        n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL sel0_err: got %b exp 0", sel_err); end
        n_cmp++; if (out !== 8'hA3) begin n_err++; $display("FAIL sel0_out: got %h exp A3", out); end
        n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL sel0_vld: got %b exp 1", out_vld); end
    endtask

    task automatic test_clr();
        fill_a0_a3();
        sel = 3'd2;
        ce = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++; if (out !== 8'h00) begin n_err++; $display("FAIL clr_out: got %h exp 00", out); end
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL clr_vld: got %b exp 0", out_vld); end
        n_cmp++; if (primed !== 1'b0) begin n_err++; $display("FAIL clr_primed: got %b exp 0", primed); end
        sel = 3'd3; #1;
        n_cmp++; if (out !== 8'h00) begin n_err++; $display("FAIL clr_tap3_out: got %h exp 00", out); end
        sel = 3'd2;
        push(8'h55, 1'b1);
        n_cmp++; if (primed !== 1'b0) begin n_err++; $display("FAIL refill1_primed: got %b exp 0", primed); end
        push(8'h66, 1'b1);
        n_cmp++; if (primed !== 1'b0) begin n_err++; $display("FAIL refill2_primed: got %b exp 0", primed); end
        push(8'h77, 1'b1);
        n_cmp++; if (primed !== 1'b1) begin n_err++; $display("FAIL refill3_primed: got %b exp 1", primed); end
        n_cmp++; if (out !== 8'h55) begin n_err++; $display("FAIL refill3_out: got %h exp 55", out); end
        // clr together with ce=1 must still flush.
        clr = 1'b1; push(8'h99, 1'b1); clr = 1'b0; ce = 1'b0;
        sel = 3'd0; #1;
        n_cmp++; if (out !== 8'h00) begin n_err++; $display("FAIL clr_ce_out: got %h exp 00", out); end
        n_cmp++; if (primed !== 1'b0) begin n_err++; $display("FAIL clr_ce_primed: got %b exp 0", primed); end
    endtask

    task automatic test_async_reset();
        fill_a0_a3();
        sel = 3'd3;
        ce = 1'b1; in = 8'hB0; in_vld = 1'b1;
        #2;
        rst_n = 1'b0;   // between edges, no clock edge involved
        #1;
        n_cmp++; if (out !== 8'h00) begin n_err++; $display("FAIL arst_out: got %h exp 00", out); end
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL arst_vld: got %b exp 0", out_vld); end
        n_cmp++; if (primed !== 1'b0) begin n_err++; $display("FAIL arst_primed: got %b exp 0", primed); end
        sel = 3'd6; #1;
        n_cmp++; if (sel_err !== 1'b1) begin n_err++; $display("FAIL arst_sel6_err: got %b exp 1", sel_err); end
        sel = 3'd1; #1;
        n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL arst_sel1_err: got %b exp 0", sel_err); end
        step();
        rst_n = 1'b1;
        sel = 3'd0;
        push(8'hC1, 1'b1);
        n_cmp++; if (out !== 8'hC1) begin n_err++; $display("FAIL arst_resume_out: got %h exp C1", out); end
        sel = 3'd1; #1;
        n_cmp++; if (out !== 8'h00) begin n_err++; $display("FAIL arst_discard_out: got %h exp 00", out); end
        ce = 1'b0;
    endtask

    task automatic test_vld_pattern();
        logic pat [4];
        logic exp_v [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        // out_vld after edge k (k=1..5) = tag pushed on edge k-1.
        exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        apply_reset();
        sel = 3'd1;
        for (int k = 0; k < 5; k++) begin
            push(8'h77, (k < 4) ? pat[k] : 1'b0);
            n_cmp++;
            if (out_vld !== exp_v[k]) begin
                n_err++; $display("FAIL vld_pat_e%0d: got %b exp %b", k + 1, out_vld, exp_v[k]);
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_saturate();
        apply_reset();
        sel = 3'd3;
        // 20 edges; a counter that wrapped would drop primed well before this.
        for (int k = 1; k <= 20; k++) begin
            push(8'(k), 1'b1);
            if (k >= 4) begin
                n_cmp++;
                if (primed !== 1'b1) begin n_err++; $display("FAIL sat_e%0d_primed: got %b exp 1", k, primed); end
            end
        end
        n_cmp++; if (out !== 8'd17) begin n_err++; $display("FAIL sat_out: got %0d exp 17", out); end
        ce = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Sequence and report
    // ---------------------------------------------------------------------
    initial begin
        test_reset();
        test_latency();
        test_ce_hold();
        test_sel_clamp();
        test_clr();
        test_async_reset();
        test_vld_pattern();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded 100000");
        $fatal(1);
    end

endmodule

// File: doc/tap_delay.md
TAP_DELAY -- requirements
Module: tap_delay

Interface
REQ-001 SHALL have parameter N, default 1: data width in bits.
REQ-002 SHALL have parameter D, default 4: number of delay stages, legal range 1..256.
REQ-003 SHALL have parameter SW, default 3: width of sel; SW >= clog2(D), and SW >= 1.
REQ-004 SHALL have port clk  input  1: single clock, rising-edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port ce  input  1: clock enable; the line shifts only on edges with ce=1.
REQ-007 SHALL have port clr  input  1: synchronous flush.
REQ-008 SHALL have port sel  input  SW: tap select.
REQ-009 SHALL have port in  input  N: data in.
REQ-010 SHALL have port in_vld  input  1: valid tag for in.
REQ-011 SHALL have port out  output  N: data at the selected tap.
REQ-012 SHALL have port out_vld  output  1: valid tag at the selected tap.
REQ-013 SHALL have port primed  output  1: selected tap written since the last reset or clr.
REQ-014 SHALL have port sel_err  output  1: sel is out of range.

Function
REQ-015 SHALL hold D data registers s[0..D-1] (N bits each), D valid bits v[0..D-1], and a fill counter cnt (clog2(D+1) bits).
REQ-016 SHALL, on a rising edge with clr=0 and ce=1: load s[0]<=in and v[0]<=in_vld; shift s[k]<=s[k-1] and v[k]<=v[k-1] for k=1..D-1; increment cnt, saturating at D.
REQ-017 SHALL, on a rising edge with clr=0 and ce=0, hold all s, v and cnt unchanged.
REQ-018 SHALL, on a rising edge with clr=1, zero all s, v and cnt; clr has priority over ce and acts when ce=0.
REQ-019 SHALL compute the effective tap t = sel when sel <= D-1, otherwise t = D-1 (clamp).
REQ-020 SHALL drive out=s[t] and out_vld=v[t] combinationally from the registers, with no added register stage.
REQ-021 SHALL drive sel_err=1 exactly when sel > D-1, combinationally, including while rst_n=0.
REQ-022 SHALL drive primed=1 exactly when cnt > t.
REQ-023 SHALL give a latency of t+1 ce-qualified edges: a sample accepted on ce edge n appears at out after ce edge n+t.
REQ-024 SHALL make a change of sel take effect in the same cycle (out, out_vld, primed and sel_err all follow); stored contents are unaffected.
REQ-025 SHALL, when D=1, use t=0 for every sel value and make sel_err=1 for any nonzero sel.
REQ-026 SHALL keep cnt saturated at D under continuous ce with no wrap-around; primed stays 1 until reset or clr.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously and without a clock edge force all s, v and cnt to 0, giving out=0, out_vld=0 and primed=0.
REQ-028 SHALL operate normally from the first rising edge after rst_n returns to 1; reset asserted mid-stream discards all in-flight data.

Verification (N=8, D=4, SW=3)
REQ-029 SHALL cover: reset; sel=2, ce=1, in_vld=1, in=0x11,0x22,0x33,0x44 on edges 1-4 -> after edge 3 out=0x11, out_vld=1, primed=1; after edge 4 out=0x22; primed=0 after edges 1-2.
REQ-030 SHALL cover: same stream with ce=0 for two cycles after edge 2 -> out, out_vld and cnt hold for two cycles; 0x11 reaches out on the 3rd ce edge.
REQ-031 SHALL cover: line full with 0xA0..0xA3 (s[3]=0xA0); sel=5 -> sel_err=1, out=0xA0; then sel=0 -> sel_err=0 and out=0xA3 in the same cycle.
REQ-032 SHALL cover: line full; clr=1 with ce=0 for one edge -> out=0, out_vld=0, primed=0 after that edge; refill requires t+1 ce edges before primed=1.
REQ-033 SHALL cover: mid-stream, rst_n pulled low between clock edges -> out=0, out_vld=0, primed=0 before the next edge, and sel_err still follows sel.
REQ-034 SHALL cover: in_vld pattern 1,0,1,1 with sel=1 -> out_vld shows 1,0,1,1 delayed by 2 ce edges, independent of data values.
